// File: rtl/zigzag_block_reader.sv
// zigzag_block_reader: takes one 8x8 coefficient block in raster order
// (index = v*8+u) and emits it in JPEG zigzag order with position tags.
// Optional feature macro: ZIGZAG_DOUBLE_BUF_EN. When defined, two banks let
// filling and draining overlap for 1 coefficient/cycle steady state. When
// undefined, a single bank alternates strictly between FILL and DRAIN.
module zigzag_block_reader #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_pos,
  output logic              out_last,
  output logic              busy
);

  // Raster index to read for each zigzag position.
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [5:0]        wr_cnt_q, wr_cnt_d;
  logic [5:0]        rd_cnt_q, rd_cnt_d;
  logic              in_fire, out_fire;
  logic [DATA_W-1:0] rd_word;

  // restart wins over both handshakes, so nothing moves in that cycle.
  assign in_fire  = in_valid  & in_ready  & ~restart;
  assign out_fire = out_valid & out_ready & ~restart;

`ifdef ZIGZAG_DOUBLE_BUF_EN

  logic [DATA_W-1:0] mem_q [2][64];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;

  // Fill side stalls only when the bank it would write still awaits draining.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign busy      = (wr_cnt_q != 6'd0) | (|full_q);
  assign rd_word   = mem_q[rd_bank_q][ZZ[rd_cnt_q]];

  // Next-state for counters, bank pointers and bank-full flags.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // Fill and drain never touch the same flag in one cycle: fill needs its
    // bank empty, drain needs its bank full.
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
    if (restart) begin
      wr_cnt_d  = 6'd0;
      rd_cnt_d  = 6'd0;
      full_d    = 2'b00;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q  <= 6'd0;
      rd_cnt_q  <= 6'd0;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Coefficient storage, written in raster order into the fill bank.
  // NOTE: the buffer is reset to zero on purpose; restart leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 64; i++)
          mem_q[b][i] <= '0;
    end else if (in_fire) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

`else

  typedef enum logic {FILL, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [64];

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (wr_cnt_q != 6'd0) | (state_q == DRAIN);
  assign rd_word   = mem_q[ZZ[rd_cnt_q]];

  // Next-state: FILL until 64 accepts, then DRAIN until 64 handshakes.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (wr_cnt_q == 6'd63) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          rd_cnt_d = rd_cnt_q + 6'd1;
          if (rd_cnt_q == 6'd63) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (restart) begin
      state_d  = FILL;
      wr_cnt_d = 6'd0;
      rd_cnt_d = 6'd0;
    end
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      wr_cnt_q <= 6'd0;
      rd_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Coefficient storage, written in raster order.
  // NOTE: the buffer is reset to zero on purpose; restart leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (in_fire) begin
      mem_q[wr_cnt_q] <= in_data;
    end
  end

`endif

  // Output fields read zero whenever no coefficient is being offered.
  assign out_data = out_valid ? rd_word : '0;
  assign out_pos  = rd_cnt_q;
  assign out_last = out_valid & (rd_cnt_q == 6'd63);

endmodule

// File: doc/zigzag_block_reader.md
Name: zigzag_block_reader

Overview:
- Consumes one 8x8 block of coefficients in raster order (u = column fastest, v = row) and re-emits it in JPEG zigzag order.
- Sits downstream of the raster (u,v) coefficient producers and feeds the entropy/run-length stage.
- valid/ready on both sides.
- Block buffer is a flop array; zigzag addressing is a 64-entry constant lookup.

Parameters:
- DATA_W, 12, coefficient width in bits (signed content, passed through untouched).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- restart  input  1  synchronous abort of the current block, active-high
- in_valid  input  1  producer has a coefficient on in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DATA_W  coefficient, raster order; raster index = v*8+u
- out_valid  output  1  out_data/out_pos/out_last valid
- out_ready  input  1  consumer accepts this cycle
- out_data  output  DATA_W  coefficient at zigzag position out_pos
- out_pos  output  6  zigzag position 0..63
- out_last  output  1  high with out_pos==63
- busy  output  1  any block partially or fully held

Behaviour:
- Reset (rst low, async): state FILL; wr_cnt=0; rd_cnt=0; buffer cleared to 0.
  - Output reset values: in_ready=1, out_valid=0, out_data=0, out_pos=0, out_last=0, busy=0.
- Input handshake: accept when in_valid&in_ready. Write mem[wr_cnt]; wr_cnt+1 (6-bit).
- FILL state:
  - in_ready=1, out_valid=0.
  - On accept with wr_cnt==63: wr_cnt wraps to 0, state -> DRAIN next cycle.
- DRAIN state:
  - in_ready=0, out_valid=1.
  - out_data=mem[ZZ[rd_cnt]], out_pos=rd_cnt, out_last=(rd_cnt==63).
  - Latency: first out_valid is the cycle after the 64th input accept.
  - Output handshake out_valid&out_ready: rd_cnt+1.
  - On handshake with rd_cnt==63: rd_cnt wraps to 0, state -> FILL.
- Stall: out_data/out_pos/out_last held stable while out_valid&!out_ready. in_data ignored when !in_ready.
- ZZ table, raster index per zigzag position:
  - first ten: 0,1,8,16,9,2,3,10,17,24
  - last six: 61,54,47,55,62,63
  - full table is the standard JPEG zigzag.
- busy=1 when wr_cnt!=0 or state==DRAIN.
- restart:
  - Overrides any handshake in the same cycle.
  - Next cycle: FILL, wr_cnt=0, rd_cnt=0, out_valid=0, in_ready=1.
  - Buffer contents are not cleared.
  - Any partial input block or partial drain is discarded.
- Reset mid-operation: immediate return to reset values; no output from the aborted block.
- Throughput, single buffer: 64 input cycles + 64 output cycles per block minimum.

Optional Feature:
- Macro: ZIGZAG_DOUBLE_BUF_EN.
- Defined:
  - Two banks. Fill bank (wr_bank) and drain bank (rd_bank) operate concurrently.
  - A full fill bank is handed to the drain side when the drain side is idle.
  - in_ready=0 only when the fill bank is complete and the drain side is still draining the other bank.
  - Bank swap on the same cycle as the 64th input accept and a last-output handshake gives a zero-bubble transition.
  - Steady-state throughput is 1 coefficient/cycle.
  - restart and reset clear both bank-full flags and both counters.
- Undefined: single bank, strictly alternating FILL/DRAIN as above.

Test Plan:
- Reset, then in_data=raster index 0..63 with in_valid=1, out_ready=1.
  - in_ready drops after 64 accepts; out_valid rises the next cycle.
  - out_data sequence 0,1,8,16,9,2,3,10,... ends 62,63; out_last only on pos 63; in_ready=1 the cycle after.
- Same block with out_ready toggling 1,0,0,1,...
  - out_data/out_pos constant across every stall cycle; all 64 values still emitted in zigzag order, no duplicates.
- Accept 20 inputs, assert restart one cycle with in_valid=1, then send a full block of 100+index.
  - First output is 100, pos 0, out_last at pos 63; none of the first 20 values appear.
- Assert rst low at drain pos 30.
  - out_valid=0, out_data=0 immediately (async); in_ready=1 after release; busy=0.
- ZIGZAG_DOUBLE_BUF_EN, back-to-back blocks A (0..63) and B (64..127), in_valid=out_ready=1 continuously.
  - in_ready stays 1 throughout; B pos 0 (value 64) follows A pos 63 with no gap cycle.
- ZIGZAG_DOUBLE_BUF_EN, out_ready=0 while sending 2 blocks.
  - in_ready=0 after 128 accepts (first block in drain bank, second block complete in fill bank); busy=1; releasing out_ready drains A then B in order.
